sum_accumulator: RTL
====================

// Module: sum_accumulator
// PURPOSE
//  Parametrised, registered successor to the combinational ui_in+uio_in adder.
//  Computes a two-operand sum or a running per-channel accumulation, with optional saturation.
//  Uses valid/ready handshakes on both input and output.
//  Sits between the tile input-pin decode and the output-pin mux of the TT user project.
// PARAMETERS
//  WIDTH   8  operand, accumulator and result width in bits (>=2)
//  NUM_CH  4  number of independent accumulator channels (power of 2, >=2)
//  SAT_EN  1  1: unsigned saturate to all-ones on overflow; 0: wrap modulo 2^WIDTH
//  CH_W    -  localparam = $clog2(NUM_CH); not user-settable
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       request present
//  in_ready   out  1       block accepts request this cycle
//  in_mode    in   2       00 ADD, 01 ACC, 10 CLR, 11 LOAD
//  in_ch      in   CH_W    target channel (ignored for ADD)
//  in_a       in   WIDTH   operand A
//  in_b       in   WIDTH   operand B (used by ADD only)
//  out_valid  out  1       result present
//  out_ready  in   1       consumer takes result this cycle
//  out_sum    out  WIDTH   result
//  out_ch     out  CH_W    channel of result (echo of in_ch)
//  out_ovf    out  1       overflow occurred on this result
//  ovf_flags  out  NUM_CH  sticky per-channel overflow flags
// BEHAVIOUR
//  Reset: sync on rst=1.
//   - Clears out_valid, out_sum, out_ch, out_ovf, ovf_flags, and every accumulator.
//   - in_ready=0 while rst=1.
//   - Any held result is discarded.
//  Handshakes:
//   - Accept = in_valid & in_ready.
//   - Output transfer = out_valid & out_ready.
//   - in_ready = !out_valid | out_ready, a combinational path from out_ready.
//  Latency and throughput:
//   - Latency 1: a request accepted at edge N appears on out_* after edge N.
//   - Throughput 1 result per cycle when out_ready is held high.
//  Stall: while out_valid & !out_ready, out_sum/out_ch/out_ovf hold stable, and no accumulator changes.
//  out_valid update: set on accept; cleared on transfer without a new accept. Transfer plus accept
//   in the same cycle keeps out_valid=1 and loads the new result.
//  Arithmetic: computed in WIDTH+1 bits; carry = bit WIDTH.
//   - SAT_EN=1: carry -> result = {WIDTH{1}}.
//   - SAT_EN=0: result = low WIDTH bits.
//   - In both cases out_ovf = carry.
//  Modes (update accumulator acc[in_ch] at the accept edge):
//   - ADD:  result = a+b; no accumulator or flag change.
//   - ACC:  result = acc[ch]+a; acc[ch] <= result; on carry, ovf_flags[ch] <= 1.
//   - CLR:  acc[ch] <= 0, ovf_flags[ch] <= 0; result = 0, out_ovf = 0.
//   - LOAD: acc[ch] <= a; result = a; out_ovf = 0; ovf_flags unchanged.
//  Back-to-back ACC on the same channel: the second request sees the updated acc with no bubble,
//   because the update is architectural at the accept edge.
//  Saturated accumulator: stays at all-ones on further ACC; out_ovf=1 each time a+acc carries.
//  A zero-operand ACC on a saturated accumulator gives out_ovf=0.
//  Reset asserted mid-stall drops the pending result; no partial update survives.
// STRUCTURE
//  Package accum_pkg:
//   - mode_e enum (MODE_ADD, MODE_ACC, MODE_CLR, MODE_LOAD).
//   - Default WIDTH/NUM_CH constants.
//  Sub-module sat_adder #(WIDTH, SAT_EN): combinational a+b -> {sum, carry}.
//   - One instance for ADD/ACC, with its operand muxed between in_b and acc[in_ch].
//  Top:
//   - Accumulator register array.
//   - Sticky flag register.
//   - Single output register stage with handshake.
// TESTING
//  1. rst 2 cycles -> out_valid=0, in_ready=0 during rst; ovf_flags=0. ACC ch0 a=0 -> out_sum=0.
//  2. WIDTH=8: ADD a=100,b=27 -> out_sum=127, out_ovf=0, one cycle later.
//     ADD a=200,b=100 -> SAT_EN=1: 255, ovf=1; SAT_EN=0: 44, ovf=1.
//  3. ACC ch2 with a=10, five back-to-back requests, out_ready=1 ->
//     out_sum 10,20,30,40,50, out_ch=2. acc[1] stays 0.
//  4. LOAD ch1 a=250, then ACC ch1 a=10 -> 255, ovf=1, ovf_flags[1]=1.
//     Then CLR ch1 -> out_sum=0, ovf_flags[1]=0.
//  5. out_ready=0 for 4 cycles after ACC ch0 a=5 -> in_ready=0, out_sum=5 held, acc[0]=5.
//     Release -> the next request completes.
//  6. Assert rst during the stall of test 5 -> out_valid=0 next cycle, acc[0]=0;
//     then ACC ch0 a=3 -> 3.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and default sizing for the sum/accumulate datapath.
package accum_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_ACC  = 2'b01,
    MODE_CLR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/sum_accumulator_if.sv
// Request/result bundle of the accumulator. Both channels are valid/ready: a beat moves on
// the rising edge where valid and ready are both high; a producer holds its payload stable until then.
interface sum_accumulator_if import accum_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              in_valid;
  logic              in_ready;
  mode_e             in_mode;
  logic [CH_W-1:0]   in_ch;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic [CH_W-1:0]   out_ch;
  logic              out_ovf;
  logic [NUM_CH-1:0] ovf_flags;

  modport master (
    output in_valid, in_mode, in_ch, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ch, out_ovf, ovf_flags
  );

  modport slave (
    input  in_valid, in_mode, in_ch, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ch, out_ovf, ovf_flags
  );

endinterface

// File: rtl/sum_accumulator_sat_adder.sv
// Combinational WIDTH-bit adder; the carry out is the overflow indication.
module sat_adder #(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[WIDTH];
  // On carry, either clamp to all-ones or let the sum wrap.
  assign o_sum   = ((SAT_EN != 0) && w_full[WIDTH]) ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Registered two-operand adder / per-channel accumulator with one output register stage.
module sum_accumulator import accum_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  sum_accumulator_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [WIDTH-1:0]  r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_flags;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_sum;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_out_ovf;

  logic              w_accept;
  logic [WIDTH-1:0]  w_acc_sel;
  logic [WIDTH-1:0]  w_opb;
  logic [WIDTH-1:0]  w_add_sum;
  logic              w_add_carry;
  logic [WIDTH-1:0]  w_result;
  logic              w_result_ovf;

  assign bus.in_ready = !rst && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  // One adder serves both ADD and ACC; only the second operand changes.
  assign w_acc_sel = r_acc[bus.in_ch];
  assign w_opb     = (bus.in_mode == MODE_ADD) ? bus.in_b : w_acc_sel;

  sat_adder #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_adder (
    .i_a     (bus.in_a),
    .i_b     (w_opb),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  always_comb begin
    w_result     = '0;
    w_result_ovf = 1'b0;
    case (bus.in_mode)
      MODE_ADD, MODE_ACC: begin
        w_result     = w_add_sum;
        w_result_ovf = w_add_carry;
      end
      MODE_LOAD: w_result = bus.in_a;
      default: begin
        w_result     = '0;
        w_result_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ch    <= '0;
      r_out_ovf   <= 1'b0;
      r_flags     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_result;
      r_out_ch    <= bus.in_ch;
      r_out_ovf   <= w_result_ovf;
      // Accumulator state commits at the accept edge so a back-to-back ACC sees it.
      case (bus.in_mode)
        MODE_ACC: begin
          r_acc[bus.in_ch] <= w_add_sum;
          if (w_add_carry) r_flags[bus.in_ch] <= 1'b1;
        end
        MODE_CLR: begin
          r_acc[bus.in_ch]   <= '0;
          r_flags[bus.in_ch] <= 1'b0;
        end
        MODE_LOAD: r_acc[bus.in_ch] <= bus.in_a;
        default: ;
      endcase
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.ovf_flags = r_flags;

endmodule
